// File: rtl/selfcomp_pkg.sv
// rtl/selfcomp_pkg.sv - shared types and helpers for the self-composition leak monitor
package selfcomp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    WAIT_ALL,
    REPORT
  } state_t;

  localparam int DEFAULT_CNT_W   = 16;
  localparam int DEFAULT_TIMEOUT = 1024;

  // Increment that sticks at the all-ones value of a width-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] limit;
    limit = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= limit) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/selfcomp_copy_tracker.sv
// rtl/selfcomp_copy_tracker.sv - per-copy arrival flag, arrival cycle and latched result
module selfcomp_copy_tracker
  import selfcomp_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              capture,
  input  logic              valid,
  input  logic [CNT_W-1:0]  cycle,
  input  logic [DATA_W-1:0] result,
  output logic              arrived,
  output logic [CNT_W-1:0]  arrival_cycle,
  output logic [DATA_W-1:0] latched_result
);

  logic              arrived_q;
  logic [CNT_W-1:0]  cycle_q;
  logic [DATA_W-1:0] result_q;
  logic              hit;

  // Only the first valid of a transaction is captured; repeats are ignored.
  assign hit = capture && valid && !arrived_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      arrived_q <= 1'b0;
      cycle_q   <= '0;
      result_q  <= '0;
    end else if (clear) begin
      arrived_q <= 1'b0;
    end else if (hit) begin
      arrived_q <= 1'b1;
      cycle_q   <= cycle;
      result_q  <= result;
    end
  end

  // Outputs include this cycle's arrival so the verdict can be formed on the completing edge.
  assign arrived        = arrived_q || hit;
  assign arrival_cycle  = hit ? cycle : cycle_q;
  assign latched_result = hit ? result : result_q;

endmodule

// File: rtl/selfcomp_leak_monitor.sv
// rtl/selfcomp_leak_monitor.sv - per-transaction skew/data verdicts across NUM_COPIES SE copies
module selfcomp_leak_monitor
  import selfcomp_pkg::*;
#(
  parameter int NUM_COPIES = 2,
  parameter int DATA_W     = 128,
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int MAX_SKEW   = 0,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int CHECK_DATA = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         ready,
  input  logic [NUM_COPIES-1:0]        copy_valid,
  input  logic [NUM_COPIES*DATA_W-1:0] copy_result,
  input  logic                         clear_stats,
  output logic                         done,
  output logic                         leak_timing,
  output logic                         leak_data,
  output logic                         timeout,
  output logic [CNT_W-1:0]             first_latency,
  output logic [CNT_W-1:0]             skew,
  output logic [NUM_COPIES-1:0]        arrived,
  output logic [CNT_W-1:0]             txn_count,
  output logic [CNT_W-1:0]             leak_count,
  output logic                         leak_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MAX_SKEW_C = CNT_W'(MAX_SKEW);

  state_t                state;
  logic [CNT_W-1:0]      cycle_cnt;
  logic [CNT_W-1:0]      cnt_now;
  logic                  capture;
  logic                  clear_trk;
  logic [NUM_COPIES-1:0] arr_eff;
  logic [CNT_W-1:0]      arr_cycle  [NUM_COPIES];
  logic [DATA_W-1:0]     arr_result [NUM_COPIES];
  logic [CNT_W-1:0]      first_cyc;
  logic [CNT_W-1:0]      last_cyc;
  logic [CNT_W-1:0]      gap;
  logic [CNT_W-1:0]      skew_calc;
  logic [DATA_W-1:0]     ref_result;
  logic                  ref_seen;
  logic                  mismatch;
  logic                  all_in;
  logic                  any_in;
  logic                  tmo_hit;
  logic                  finish;

  // cnt_now is the cycle index of the current edge; the first edge after start is 1.
  assign cnt_now   = CNT_W'(sat_inc(32'(cycle_cnt), CNT_W));
  assign capture   = (state == WAIT_FIRST) || (state == WAIT_ALL);
  assign clear_trk = (state == IDLE) && start;

  for (genvar i = 0; i < NUM_COPIES; i++) begin : g_copy
    selfcomp_copy_tracker #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
    ) u_trk (
      .clock         (clock),
      .reset         (reset),
      .clear         (clear_trk),
      .capture       (capture),
      .valid         (copy_valid[i]),
      .cycle         (cnt_now),
      .result        (copy_result[i*DATA_W +: DATA_W]),
      .arrived       (arr_eff[i]),
      .arrival_cycle (arr_cycle[i]),
      .latched_result(arr_result[i])
    );
  end

  always_comb begin
    first_cyc  = CNT_MAX;
    last_cyc   = '0;
    ref_result = '0;
    ref_seen   = 1'b0;
    mismatch   = 1'b0;
    for (int i = 0; i < NUM_COPIES; i++) begin
      if (arr_eff[i]) begin
        if (arr_cycle[i] < first_cyc) first_cyc = arr_cycle[i];
        if (arr_cycle[i] > last_cyc)  last_cyc  = arr_cycle[i];
        if (!ref_seen) begin
          ref_result = arr_result[i];
          ref_seen   = 1'b1;
        end else if (arr_result[i] != ref_result) begin
          mismatch = 1'b1;
        end
      end
    end
  end

  assign all_in = &arr_eff;
  assign any_in = |arr_eff;
  assign gap    = cnt_now - first_cyc;

  // A stuck (saturated) cycle counter also ends WAIT_ALL so the monitor can never hang.
  always_comb begin
    tmo_hit = 1'b0;
    finish  = 1'b0;
    case (state)
      WAIT_FIRST: begin
        tmo_hit = !any_in && (cycle_cnt == CNT_MAX);
        finish  = all_in || tmo_hit;
      end
      WAIT_ALL: begin
        tmo_hit = !all_in && ((gap >= TIMEOUT_C) || (cycle_cnt == CNT_MAX));
        finish  = all_in || tmo_hit;
      end
      default: ;
    endcase
  end

  assign skew_calc = tmo_hit ? TIMEOUT_C : (last_cyc - first_cyc);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      ready         <= 1'b1;
      done          <= 1'b0;
      leak_timing   <= 1'b0;
      leak_data     <= 1'b0;
      timeout       <= 1'b0;
      first_latency <= '0;
      skew          <= '0;
      arrived       <= '0;
      txn_count     <= '0;
      leak_count    <= '0;
      leak_sticky   <= 1'b0;
      cycle_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WAIT_FIRST;
            ready     <= 1'b0;
            cycle_cnt <= '0;
          end
        end
        WAIT_FIRST, WAIT_ALL: begin
          cycle_cnt <= cnt_now;
          if (finish) begin
            state         <= REPORT;
            done          <= 1'b1;
            timeout       <= tmo_hit;
            leak_timing   <= tmo_hit || (skew_calc > MAX_SKEW_C);
            leak_data     <= (CHECK_DATA != 0) && mismatch;
            first_latency <= first_cyc;
            skew          <= skew_calc;
            arrived       <= arr_eff;
          end else if (any_in) begin
            state <= WAIT_ALL;
          end
        end
        REPORT: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Statistics fold in the verdict on the done cycle; a coincident clear takes priority.
      if (clear_stats) begin
        txn_count   <= '0;
        leak_count  <= '0;
        leak_sticky <= 1'b0;
      end else if (state == REPORT) begin
        txn_count <= CNT_W'(sat_inc(32'(txn_count), CNT_W));
        if (leak_timing || leak_data) begin
          leak_count  <= CNT_W'(sat_inc(32'(leak_count), CNT_W));
          leak_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_selfcomp_leak_monitor.sv
// tb/tb_selfcomp_leak_monitor.sv - directed self-checking bench for selfcomp_leak_monitor
module tb_selfcomp_leak_monitor;

  logic        clk;
  logic        rst_n;
  logic        start2, start4, clr2, clr4;
  logic [1:0]  cv2;
  logic [3:0]  cv4;
  logic [15:0] cr2;
  logic [31:0] cr4;

  logic        ready2, done2, lt2, ld2, to2, ls2;
  logic [15:0] fl2, sk2, tc2, lc2;
  logic [1:0]  arr2;
  logic        ready4, done4, lt4, ld4, to4, ls4;
  logic [15:0] fl4, sk4, tc4, lc4;
  logic [3:0]  arr4;

  int checks;
  int failures;
  int dc;
  int seen;

  selfcomp_leak_monitor #(
    .NUM_COPIES(2), .DATA_W(8), .CNT_W(16), .MAX_SKEW(0), .TIMEOUT(16), .CHECK_DATA(1)
  ) dut2 (
    .clock(clk), .reset(rst_n), .start(start2), .ready(ready2),
    .copy_valid(cv2), .copy_result(cr2), .clear_stats(clr2),
    .done(done2), .leak_timing(lt2), .leak_data(ld2), .timeout(to2),
    .first_latency(fl2), .skew(sk2), .arrived(arr2),
    .txn_count(tc2), .leak_count(lc2), .leak_sticky(ls2)
  );

  selfcomp_leak_monitor #(
    .NUM_COPIES(4), .DATA_W(8), .CNT_W(16), .MAX_SKEW(2), .TIMEOUT(16), .CHECK_DATA(1)
  ) dut4 (
    .clock(clk), .reset(rst_n), .start(start4), .ready(ready4),
    .copy_valid(cv4), .copy_result(cr4), .clear_stats(clr4),
    .done(done4), .leak_timing(lt4), .leak_data(ld4), .timeout(to4),
    .first_latency(fl4), .skew(sk4), .arrived(arr4),
    .txn_count(tc4), .leak_count(lc4), .leak_sticky(ls4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Latency n means the copy's valid is sampled on the n-th edge after the start edge; 0 = never.
  // Returns one edge after done was seen, so statistics already include the transaction.
  task automatic run_txn(input bit four, input int l0, input int l1, input int l2, input int l3,
                         input logic [31:0] res, input bit busy, input bit clr, input bit vstart,
                         output int done_cyc);
    int         lat [4];
    logic [3:0] vb;
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    done_cyc = -1;
    if (four) begin
      start4 = 1'b1; cr4 = res; cv4 = vstart ? 4'hF : 4'h0;
    end else begin
      start2 = 1'b1; cr2 = res[15:0]; cv2 = vstart ? 2'b11 : 2'b00;
    end
    @(negedge clk);
    if (!busy) begin
      start2 = 1'b0; start4 = 1'b0;
    end
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      for (int i = 0; i < 4; i++) vb[i] = (lat[i] == cyc);
      if (four) cv4 = vb; else cv2 = vb[1:0];
      @(negedge clk);
      if (four ? done4 : done2) done_cyc = cyc;
    end
    start2 = 1'b0; start4 = 1'b0; cv2 = '0; cv4 = '0;
    if (four) clr4 = clr; else clr2 = clr;
    @(negedge clk);
    clr2 = 1'b0; clr4 = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start2 = 0; start4 = 0; clr2 = 0; clr4 = 0;
    cv2 = '0; cv4 = '0; cr2 = '0; cr4 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_ready", ready2, 1);
    check("rst_done", done2, 0);
    check("rst_flags", {lt2, ld2, to2, ls2}, 4'b0000);
    check("rst_counts", {fl2, sk2, tc2, lc2}, 64'h0);
    check("rst_arrived", arr2, 2'b00);
    check("rst_ready4", ready4, 1);

    // equal latency
    run_txn(0, 5, 5, 0, 0, 32'h0000_A5A5, 0, 0, 0, dc);
    check("eq_done_cyc", dc, 5);
    check("eq_first", fl2, 5);
    check("eq_skew", sk2, 0);
    check("eq_leaks", {lt2, ld2, to2}, 3'b000);
    check("eq_arrived", arr2, 2'b11);
    check("eq_txn", tc2, 1);
    check("eq_done_pulse", done2, 0);
    check("eq_ready", ready2, 1);

    // skew 3 with MAX_SKEW 0
    run_txn(0, 4, 7, 0, 0, 32'h0000_5555, 0, 0, 0, dc);
    check("skew_done_cyc", dc, 7);
    check("skew_val", sk2, 3);
    check("skew_first", fl2, 4);
    check("skew_leaks", {lt2, ld2, to2}, 3'b100);
    check("skew_lc", lc2, 1);
    check("skew_sticky", ls2, 1);
    check("skew_txn", tc2, 2);

    // data mismatch: copy0 0x10, copy1 0x11
    run_txn(0, 3, 3, 0, 0, 32'h0000_1110, 0, 0, 0, dc);
    check("data_done_cyc", dc, 3);
    check("data_leaks", {lt2, ld2, to2}, 3'b010);
    check("data_lc", lc2, 2);

    // copy1 never arrives
    run_txn(0, 4, 0, 0, 0, 32'h0000_7777, 0, 0, 0, dc);
    check("tmo_done_cyc", dc, 20);
    check("tmo_flags", {lt2, ld2, to2}, 3'b101);
    check("tmo_arrived", arr2, 2'b01);
    check("tmo_skew", sk2, 16);
    check("tmo_first", fl2, 4);
    check("tmo_lc", lc2, 3);
    check("tmo_txn", tc2, 4);

    // completes exactly at the timeout distance: full mask wins
    run_txn(0, 2, 18, 0, 0, 32'h0000_3333, 0, 0, 0, dc);
    check("edge_done_cyc", dc, 18);
    check("edge_flags", {lt2, ld2, to2}, 3'b100);
    check("edge_skew", sk2, 16);

    // start held while busy and valids during the start cycle are ignored
    run_txn(0, 3, 3, 0, 0, 32'h0000_AAAA, 1, 0, 1, dc);
    check("busy_done_cyc", dc, 3);
    check("busy_first", fl2, 3);
    check("busy_txn", tc2, 6);
    check("busy_ready", ready2, 1);

    // reset while in WAIT_ALL
    start2 = 1'b1; cr2 = 16'h0101;
    @(negedge clk); start2 = 1'b0; cv2 = 2'b01;
    @(negedge clk); cv2 = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("mid_rst_ready", ready2, 1);
    check("mid_rst_flags", {done2, lt2, ld2, to2, ls2}, 5'b00000);
    check("mid_rst_counts", {fl2, sk2, tc2, lc2}, 64'h0);
    check("mid_rst_arrived", arr2, 2'b00);
    cv2 = 2'b10; seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cv2 = 2'b00;
      if (done2) seen++;
    end
    check("mid_rst_no_done", seen, 0);

    // clear_stats during the done cycle wins over the count
    run_txn(0, 3, 3, 0, 0, 32'h0000_2222, 0, 0, 0, dc);
    check("pre_clr_txn", tc2, 1);
    run_txn(0, 2, 4, 0, 0, 32'h0000_2222, 0, 1, 0, dc);
    check("clr_verdict", {lt2, sk2}, {1'b1, 16'd2});
    check("clr_stats", {tc2, lc2, 15'd0, ls2}, 48'h0);

    // four copies, MAX_SKEW 2
    run_txn(1, 6, 6, 7, 8, 32'h5A5A_5A5A, 0, 0, 0, dc);
    check("four_done_cyc", dc, 8);
    check("four_skew", sk4, 2);
    check("four_first", fl4, 6);
    check("four_leaks", {lt4, ld4, to4}, 3'b000);
    check("four_arrived", arr4, 4'b1111);
    check("four_txn", tc4, 1);

    run_txn(1, 6, 6, 7, 9, 32'h3C5A_5A5A, 0, 0, 0, dc);
    check("four_b_skew", sk4, 3);
    check("four_b_leaks", {lt4, ld4, to4}, 3'b110);
    check("four_b_stats", {tc4, lc4, 15'd0, ls4}, {16'd2, 16'd1, 16'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/selfcomp_leak_monitor.md
Name: selfcomp_leak_monitor

Overview:
- Parametrised self-composition checker that observes NUM_COPIES identical SE instances driven by the same instruction stream.
- Measures per-transaction completion skew across copies and flags timing leaks (skew > MAX_SKEW, or a copy timing out).
- Optionally flags data divergence between the copies' results.
- Sits beside the SE copies inside a selfcomp tester, replacing purely combinational valid comparison with a cycle-accurate, per-transaction verdict plus running statistics.

Parameters:
- NUM_COPIES, 2, number of SE copies observed (2..8).
- DATA_W, 128, width of each copy's result.
- CNT_W, 16, width of latency, skew and statistic counters.
- MAX_SKEW, 0, largest tolerated difference in completion cycle between earliest and latest copy.
- TIMEOUT, 1024, cycles after the first arrival before the remaining copies are declared missing.
- CHECK_DATA, 1, when 1, compare latched results across copies.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  transaction issued to all copies (io_in_valid & io_in_ready at the SE boundary); accepted only when ready=1.
- ready  out  1  monitor idle and able to accept start.
- copy_valid  in  NUM_COPIES  per-copy io_out_valid.
- copy_result  in  NUM_COPIES*DATA_W  per-copy io_out_result; copy i occupies bits [i*DATA_W +: DATA_W].
- clear_stats  in  1  synchronous clear of statistics and sticky flags.
- done  out  1  one-cycle pulse: verdict outputs valid.
- leak_timing  out  1  verdict: skew > MAX_SKEW or timeout; valid with done.
- leak_data  out  1  verdict: result mismatch; valid with done; 0 when CHECK_DATA=0.
- timeout  out  1  verdict: at least one copy never arrived; valid with done.
- first_latency  out  CNT_W  cycles from start to the earliest arrival; valid with done.
- skew  out  CNT_W  last minus first arrival cycle; saturates at TIMEOUT on timeout.
- arrived  out  NUM_COPIES  arrival mask at verdict time.
- txn_count  out  CNT_W  completed transactions; saturating.
- leak_count  out  CNT_W  transactions with leak_timing or leak_data; saturating.
- leak_sticky  out  1  set by any leak, cleared only by reset or clear_stats.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE, ready=1.
  - done, leak_timing, leak_data, timeout, leak_sticky = 0.
  - first_latency, skew, arrived, txn_count, leak_count = 0.
  - Reset mid-transaction abandons it and produces no done.
- States: IDLE -> WAIT_FIRST -> WAIT_ALL -> REPORT -> IDLE.
- IDLE:
  - ready=1.
  - start=1 moves to WAIT_FIRST and zeroes the cycle counter and the arrival mask.
- WAIT_FIRST:
  - The cycle counter increments every cycle; count 1 is the cycle after start.
  - On any copy_valid bit: record first_latency=counter, set those mask bits, latch those results.
  - If all bits arrive together, go directly to REPORT with skew=0; otherwise go to WAIT_ALL.
  - A copy_valid asserted in the same cycle as start is ignored.
- WAIT_ALL:
  - Each newly seen copy_valid sets its mask bit and latches that copy's result.
  - Valids from copies already arrived are ignored.
  - When the mask is full: skew = counter - first_latency; go to REPORT.
  - If counter - first_latency reaches TIMEOUT first: timeout=1, skew=TIMEOUT; go to REPORT.
- REPORT (exactly one cycle):
  - done=1.
  - leak_timing = timeout | (skew > MAX_SKEW).
  - leak_data = CHECK_DATA & (any arrived copy's latched result != the lowest-index arrived copy's result).
  - txn_count increments.
  - leak_count increments if leak_timing|leak_data.
  - leak_sticky |= leak_timing|leak_data.
  - Next state IDLE.
- Verdict outputs hold their values until the next REPORT; only done pulses.
- start while ready=0 is ignored. No queueing; the upstream SE serialises transactions.
- Counters saturate at all-ones and never wrap. The cycle counter saturates too; a saturated cycle counter forces a timeout in WAIT_FIRST.
- clear_stats zeroes txn_count, leak_count and leak_sticky. When it coincides with REPORT, the clear wins and this transaction is not counted.

Decomposition:
- Package selfcomp_pkg holds:
  - the state enum (IDLE, WAIT_FIRST, WAIT_ALL, REPORT);
  - the saturating-increment function;
  - the default constants for CNT_W and TIMEOUT.
- Sub-module selfcomp_copy_tracker is instantiated NUM_COPIES times. Each instance holds:
  - that copy's arrival flag and arrival-cycle capture;
  - that copy's latched result.
- The top level owns the FSM, the first/last reduction, the comparison tree and the statistics.

Test Plan:
- Equal latency: NUM_COPIES=2, start, both copies valid 5 cycles later with results 0xA5 -> done, first_latency=5, skew=0, leak_timing=0, leak_data=0, txn_count=1.
- Skew: copy0 valid at cycle 4, copy1 at cycle 7, MAX_SKEW=0 -> skew=3, leak_timing=1, leak_count=1, leak_sticky=1.
- Data mismatch: both copies valid at cycle 3, results 0x10 and 0x11, CHECK_DATA=1 -> leak_data=1, leak_timing=0.
- Timeout: TIMEOUT=16, copy1 never valid -> done 16 cycles after copy0's arrival, timeout=1, arrived=2'b01, skew=16.
- Reset and control: reset=0 asserted in WAIT_ALL -> no done, all outputs 0, ready=1 next cycle; start while busy ignored; clear_stats during REPORT leaves txn_count=0.
- Four copies (NUM_COPIES=4, MAX_SKEW=2): arrivals at cycles 6, 6, 7, 8 -> skew=2, leak_timing=0, arrived=4'b1111.
